// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared FSM states, access-size codes and IO window constants
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    LSB_RD = 2'd2,
    LSB_WR = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] IO_SEL    = 2'b11;
  localparam int         IO_BIT_HI = 17;

  // Index of the final byte of a transfer; the reserved size 11 behaves as word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 2'd0;
      SIZE_HALF: return 2'd1;
      default:   return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - fetch, load/store and byte-wide memory bus bundle
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;

  logic                  lsb_req;
  logic                  lsb_wr;
  logic [1:0]            lsb_size;
  logic [ADDR_WIDTH-1:0] lsb_addr;
  logic [31:0]           lsb_wdata;
  logic                  lsb_done;
  logic [31:0]           lsb_rdata;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  modport slave (
    input  if_req, if_addr, lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata, mem_din,
    output if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr, lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata, mem_din,
    input  if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates fetch and load/store requests onto a byte-wide memory bus
// Reads capture one byte per cycle from a combinational memory; stores drive one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  mem_ctrl_if.slave   bus
);

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            last_q, last_d;
  logic [31:0]           buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [7:0]            dout_q, dout_d;
  logic                  wr_q, wr_d;
  logic                  if_done_q, if_done_d;
  logic                  lsb_done_q, lsb_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           lsb_rdata_q, lsb_rdata_d;

  logic io_block;
  logic lsb_go;
  logic can_accept;

  // A store into the UART window waits while its transmit buffer is full.
  assign io_block   = bus.lsb_wr && (bus.lsb_addr[IO_BIT_HI -: 2] == IO_SEL) && io_buffer_full;
  assign lsb_go     = bus.lsb_req && !io_block;
  assign can_accept = !if_done_q && !lsb_done_q && !clear;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    buf_d       = buf_q;
    a_d         = a_q;
    dout_d      = dout_q;
    wr_d        = 1'b0;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;

    case (state_q)
      IDLE: begin
        if (can_accept) begin
          if (lsb_go) begin
            idx_d  = 2'd0;
            buf_d  = 32'd0;
            last_d = last_idx(bus.lsb_size);
            a_d    = bus.lsb_addr;
            if (bus.lsb_wr) begin
              state_d = LSB_WR;
              wr_d    = 1'b1;
              dout_d  = byte_of(bus.lsb_wdata, 2'd0);
            end else begin
              state_d = LSB_RD;
            end
          end else if (bus.if_req) begin
            state_d = IF_RD;
            idx_d   = 2'd0;
            buf_d   = 32'd0;
            last_d  = 2'd3;
            a_d     = bus.if_addr;
          end
        end
      end

      IF_RD, LSB_RD: begin
        if (clear) begin
          state_d = IDLE;
        end else begin
          buf_d[{idx_q, 3'b000} +: 8] = bus.mem_din;
          if (idx_q == last_q) begin
            state_d = IDLE;
            if (state_q == IF_RD) begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_d;
            end
          end else begin
            idx_d = idx_q + 2'd1;
            a_d   = a_q + ADDR_WIDTH'(1);
          end
        end
      end

      // Stores are already committed to the bus, so clear does not cut them short.
      LSB_WR: begin
        if (idx_q == last_q) begin
          state_d    = IDLE;
          lsb_done_d = 1'b1;
        end else begin
          idx_d  = idx_q + 2'd1;
          a_d    = a_q + ADDR_WIDTH'(1);
          wr_d   = 1'b1;
          dout_d = byte_of(bus.lsb_wdata, idx_q + 2'd1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      buf_q       <= 32'd0;
      a_q         <= '0;
      dout_q      <= 8'd0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= 32'd0;
      lsb_rdata_q <= 32'd0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      buf_q       <= buf_d;
      a_q         <= a_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;
  assign bus.mem_a     = a_q;
  assign bus.mem_dout  = dout_q;
  assign bus.mem_wr    = wr_q & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed bench for mem_ctrl with a combinational byte memory
module tb_mem_ctrl;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic clear = 1'b0;
  logic io_buffer_full = 1'b0;

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .bus            (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram [0:65535];
  bit         loaded = 1'b0;
  int         wr_count = 0;
  int         if_done_count = 0;

  assign bus.mem_din = ram[bus.mem_a[15:0]];

  // Memory image is loaded on the first edge so one process owns the array.
  always @(posedge clk_in) begin
    if (!loaded) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
      ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h05; ram[16'h0102] <= 8'h00; ram[16'h0103] <= 8'h00;
      ram[16'h0200] <= 8'h11; ram[16'h0201] <= 8'h22; ram[16'h0202] <= 8'h33; ram[16'h0203] <= 8'h44;
      ram[16'h0300] <= 8'h99; ram[16'h0301] <= 8'h99; ram[16'h0302] <= 8'h99; ram[16'h0303] <= 8'h99;
      ram[16'h0400] <= 8'h78; ram[16'h0401] <= 8'h56; ram[16'h0402] <= 8'h34; ram[16'h0403] <= 8'h12;
      ram[16'h0500] <= 8'hEF; ram[16'h0501] <= 8'hBE; ram[16'h0502] <= 8'hAD; ram[16'h0503] <= 8'hDE;
      ram[16'hFFFE] <= 8'hAA; ram[16'hFFFF] <= 8'hBB; ram[16'h0000] <= 8'hCC; ram[16'h0001] <= 8'hDD;
      loaded <= 1'b1;
    end else if (bus.mem_wr) begin
      ram[bus.mem_a[15:0]] <= bus.mem_dout;
      wr_count <= wr_count + 1;
    end
  end

  always @(negedge clk_in) begin
    if (bus.if_done) if_done_count <= if_done_count + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  int snap;

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_size = 2'b00;
    bus.lsb_addr = '0; bus.lsb_wdata = '0;

    cycles(3);
    check("rst_if_done", {31'd0, bus.if_done}, 32'd0);
    check("rst_lsb_done", {31'd0, bus.lsb_done}, 32'd0);
    check("rst_if_data", bus.if_data, 32'd0);
    check("rst_lsb_rdata", bus.lsb_rdata, 32'd0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    rst_in = 1'b0;
    cycles(1);

    // Instruction fetch from 0x100
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    cycles(1);
    check("if_a0", bus.mem_a, 32'h100);
    for (int j = 1; j < 4; j++) begin
      cycles(1);
      check("if_aj", bus.mem_a, 32'h100 + j);
      check("if_done_early", {31'd0, bus.if_done}, 32'd0);
    end
    cycles(1);
    check("if_done", {31'd0, bus.if_done}, 32'd1);
    check("if_data", bus.if_data, 32'h0000_0513);
    bus.if_req = 1'b0;
    cycles(1);
    check("if_done_pulse", {31'd0, bus.if_done}, 32'd0);
    check("if_data_hold", bus.if_data, 32'h0000_0513);

    // Simultaneous fetch and word load: load first
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_size = 2'b10; bus.lsb_addr = 32'h200;
    cycles(1);
    check("prio_a", bus.mem_a, 32'h200);
    cycles(3);
    check("prio_lsb_early", {31'd0, bus.lsb_done}, 32'd0);
    cycles(1);
    check("prio_lsb_done", {31'd0, bus.lsb_done}, 32'd1);
    check("prio_lsb_rdata", bus.lsb_rdata, 32'h4433_2211);
    check("prio_if_wait", {31'd0, bus.if_done}, 32'd0);
    bus.lsb_req = 1'b0;
    cycles(1);
    check("prio_idle_a", bus.mem_a, 32'h203);
    cycles(1);
    check("prio_if_accept", bus.mem_a, 32'h100);
    cycles(4);
    check("prio_if_done", {31'd0, bus.if_done}, 32'd1);
    check("prio_if_data", bus.if_data, 32'h0000_0513);
    bus.if_req = 1'b0;
    cycles(1);

    // Byte load is zero-extended
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_size = 2'b00; bus.lsb_addr = 32'h203;
    cycles(2);
    check("lb_done", {31'd0, bus.lsb_done}, 32'd1);
    check("lb_rdata", bus.lsb_rdata, 32'h0000_0044);
    bus.lsb_req = 1'b0;
    cycles(1);

    // Half store
    snap = wr_count;
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_size = 2'b01;
    bus.lsb_addr = 32'h1000; bus.lsb_wdata = 32'hAABB_CCDD;
    cycles(1);
    check("sh_wr0", {31'd0, bus.mem_wr}, 32'd1);
    check("sh_a0", bus.mem_a, 32'h1000);
    check("sh_d0", {24'd0, bus.mem_dout}, 32'hDD);
    cycles(1);
    check("sh_wr1", {31'd0, bus.mem_wr}, 32'd1);
    check("sh_a1", bus.mem_a, 32'h1001);
    check("sh_d1", {24'd0, bus.mem_dout}, 32'hCC);
    cycles(1);
    check("sh_wr_end", {31'd0, bus.mem_wr}, 32'd0);
    check("sh_done", {31'd0, bus.lsb_done}, 32'd1);
    bus.lsb_req = 1'b0;
    cycles(1);
    check("sh_count", wr_count - snap, 32'd2);
    check("sh_mem", {ram[16'h1002], ram[16'h1001], ram[16'h1000]}, 32'h0000_CCDD);
    check("sh_rdata_hold", bus.lsb_rdata, 32'h0000_0044);

    // Clear during a fetch, then a new fetch is accepted
    snap = if_done_count;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    cycles(2);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    bus.if_addr = 32'h400;
    check("clr_no_done", {31'd0, bus.if_done}, 32'd0);
    cycles(1);
    check("clr_reaccept", bus.mem_a, 32'h400);
    cycles(3);
    check("clr_no_pulse", if_done_count - snap, 32'd0);
    cycles(1);
    check("clr_if_done", {31'd0, bus.if_done}, 32'd1);
    check("clr_if_data", bus.if_data, 32'h1234_5678);
    bus.if_req = 1'b0;
    cycles(1);

    // Clear during a word store does not stop it
    snap = wr_count;
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_size = 2'b10;
    bus.lsb_addr = 32'h2000; bus.lsb_wdata = 32'h0403_0201;
    cycles(1);
    clear = 1'b1;
    cycles(3);
    check("clr_st_wr", {31'd0, bus.mem_wr}, 32'd1);
    cycles(1);
    check("clr_st_done", {31'd0, bus.lsb_done}, 32'd1);
    clear = 1'b0; bus.lsb_req = 1'b0;
    cycles(1);
    check("clr_st_count", wr_count - snap, 32'd4);
    check("clr_st_mem", {ram[16'h2003], ram[16'h2002], ram[16'h2001], ram[16'h2000]}, 32'h0403_0201);

    // Fetch across the top of the address space wraps to zero
    bus.if_req = 1'b1; bus.if_addr = 32'hFFFF_FFFE;
    cycles(2);
    check("wrap_a1", bus.mem_a, 32'hFFFF_FFFF);
    cycles(1);
    check("wrap_a2", bus.mem_a, 32'h0000_0000);
    cycles(2);
    check("wrap_done", {31'd0, bus.if_done}, 32'd1);
    check("wrap_data", bus.if_data, 32'hDDCC_BBAA);
    bus.if_req = 1'b0;
    cycles(1);

    // UART store stalls while the buffer is full
    snap = wr_count;
    io_buffer_full = 1'b1;
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_size = 2'b00;
    bus.lsb_addr = 32'h0003_0000; bus.lsb_wdata = 32'h0000_005A;
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      check("io_stall_wr", {31'd0, bus.mem_wr}, 32'd0);
    end
    check("io_stall_count", wr_count - snap, 32'd0);
    io_buffer_full = 1'b0;
    cycles(1);
    check("io_wr", {31'd0, bus.mem_wr}, 32'd1);
    check("io_a", bus.mem_a, 32'h0003_0000);
    check("io_d", {24'd0, bus.mem_dout}, 32'h5A);
    cycles(1);
    check("io_done", {31'd0, bus.lsb_done}, 32'd1);
    bus.lsb_req = 1'b0;
    cycles(1);

    // Pause in the middle of a word load
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_size = 2'b10; bus.lsb_addr = 32'h500;
    cycles(2);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycles(1);
      check("pause_a", bus.mem_a, 32'h501);
      check("pause_wr", {31'd0, bus.mem_wr}, 32'd0);
      check("pause_done", {31'd0, bus.lsb_done}, 32'd0);
    end
    rdy_in = 1'b1;
    cycles(3);
    check("pause_lsb_done", {31'd0, bus.lsb_done}, 32'd1);
    check("pause_rdata", bus.lsb_rdata, 32'hDEAD_BEEF);
    bus.lsb_req = 1'b0;
    cycles(1);

    // Pause gates mem_wr during a store
    snap = wr_count;
    bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_size = 2'b00;
    bus.lsb_addr = 32'h600; bus.lsb_wdata = 32'h0000_0077;
    cycles(1);
    rdy_in = 1'b0;
    #1;
    check("pause_st_gate", {31'd0, bus.mem_wr}, 32'd0);
    cycles(2);
    rdy_in = 1'b1;
    #1;
    check("pause_st_resume", {31'd0, bus.mem_wr}, 32'd1);
    cycles(1);
    check("pause_st_done", {31'd0, bus.lsb_done}, 32'd1);
    bus.lsb_req = 1'b0;
    cycles(1);
    check("pause_st_count", wr_count - snap, 32'd1);
    check("pause_st_mem", {24'd0, ram[16'h0600]}, 32'h77);

    // Reset mid-fetch discards the transaction
    snap = if_done_count;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    cycles(2);
    rst_in = 1'b1;
    #1;
    check("arst_mem_a", bus.mem_a, 32'd0);
    cycles(1);
    rst_in = 1'b0;
    bus.if_req = 1'b0;
    cycles(6);
    check("arst_no_done", if_done_count - snap, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of all address ports.
REQ-002 SHALL have port clk_in  input  1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port rdy_in  input  1: high = run; low = pause.
REQ-005 SHALL have port clear  input  1: pipeline flush.
REQ-006 SHALL have port if_req  input  1: fetch request, held high until if_done.
REQ-007 SHALL have port if_addr  input  ADDR_WIDTH: fetch base address.
REQ-008 SHALL have port if_done  output  1: one-cycle pulse; if_data valid.
REQ-009 SHALL have port if_data  output  32: fetched word, little-endian.
REQ-010 SHALL have port lsb_req  input  1: load/store request, held high until lsb_done.
REQ-011 SHALL have port lsb_wr  input  1: 1 = store, 0 = load.
REQ-012 SHALL have port lsb_size  input  2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-013 SHALL have port lsb_addr  input  ADDR_WIDTH: load/store base address.
REQ-014 SHALL have port lsb_wdata  input  32: store data; low bytes are used first.
REQ-015 SHALL have port lsb_done  output  1: one-cycle completion pulse.
REQ-016 SHALL have port lsb_rdata  output  32: load data, zero-extended.
REQ-017 SHALL have ports mem_din  input  8, mem_dout  output  8, mem_a  output  ADDR_WIDTH, mem_wr  output  1 (1 = write): the shared memory bus.
REQ-018 SHALL have port io_buffer_full  input  1: UART transmit buffer full.

Function
REQ-019 SHALL implement a state machine with states IDLE, IF_RD, LSB_RD, LSB_WR and a 2-bit byte index.
REQ-020 SHALL accept requests only in IDLE, and not in a cycle where if_done or lsb_done is 1 or clear is 1.
REQ-021 SHALL give lsb_req fixed priority over if_req when both are pending at acceptance.
REQ-022 SHALL not accept a store when lsb_addr[17:16]==2'b11 and io_buffer_full=1; the request stays pending until io_buffer_full is low.
REQ-023 SHALL set transaction length N: 4 for fetches; 1, 2 or 4 for LSB transactions per lsb_size.
REQ-024 SHALL, for a read accepted at edge t0, drive mem_a=base from t0, and at edge t0+j (j=1..N) capture mem_din as byte j-1 and drive mem_a=base+j when j<N.
REQ-025 SHALL, at edge t0+N of a read, pulse the matching done output for exactly one cycle, present the assembled data on the matching data output, and return to IDLE.
REQ-026 SHALL, for a store accepted at t0, drive mem_wr=1, mem_a=base+j and mem_dout=lsb_wdata[8j+7:8j] for cycle j=0..N-1, then at edge t0+N drive mem_wr=0, pulse lsb_done and return to IDLE.
REQ-027 SHALL compute address increments modulo 2^ADDR_WIDTH (wrap-around allowed).
REQ-028 SHALL, when clear=1 at an edge during IF_RD or LSB_RD, abort to IDLE with no done pulse and mem_wr=0.
REQ-029 SHALL complete an LSB_WR in progress despite clear, because stores are committed.
REQ-030 SHALL hold mem_wr=0 and mem_a stable in IDLE.
REQ-031 SHALL freeze all registers while rdy_in=0, with mem_wr forced to 0 combinationally; the system contract holds mem_din stable across a pause.
REQ-032 SHALL hold if_data and lsb_rdata at their last values outside done cycles.

Reset
REQ-033 SHALL, on rst_in=1 (asynchronous), enter IDLE and set byte index=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0, mem_a=0, mem_dout=0, mem_wr=0.
REQ-034 SHALL discard an in-flight transaction on reset mid-operation and produce no done pulse afterwards.

Structure
REQ-035 SHALL take from shared package mem_ctrl_pkg: the state enum, the size encodings, and constants IO_SEL=2'b11 and IO_BIT_HI=17.
REQ-036 SHALL be a single flat FSM with no sub-module.

Verification
REQ-037 SHALL cover an IF fetch: if_addr=0x100 with memory bytes 13,05,00,00 -> mem_a steps 0x100..0x103, if_done at t0+4, if_data=0x00000513.
REQ-038 SHALL cover a simultaneous request: if_req and lsb_req (load word at 0x200) both high -> the LSB is served first, and the IF is accepted on the second edge after lsb_done.
REQ-039 SHALL cover a half store: lsb_wdata=0xAABBCCDD to 0x1000 -> mem_wr=1 for 2 cycles writing DD@0x1000 and CC@0x1001, then lsb_done.
REQ-040 SHALL cover clear during a fetch: clear at t0+2 of a fetch -> IDLE, no if_done, and the next request is accepted; clear during a store -> all 4 bytes are still written.
REQ-041 SHALL cover an IO stall: byte store to 0x30000 with io_buffer_full=1 for 5 cycles -> no mem_wr, then the write is issued after full drops.
REQ-042 SHALL cover a pause: rdy_in=0 for 3 cycles mid-read -> mem_wr=0, state frozen, and the read data after resume is correct.
